bin_demux_dec: RTL and testbench

BIN_DEMUX_DEC -- requirements
Module: bin_demux_dec

---
 rtl/bin_demux_dec_pkg.sv | 48 ++++
 rtl/bin_demux_dec_onehot.sv | 30 +++
 rtl/bin_demux_dec.sv | 150 +++++++++++++++
 tb/tb_bin_demux_dec.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bin_demux_dec_pkg.sv
// -----------------------------------------------------------------------------
// bin_demux_dec_pkg
//   Shared sink defines and types for the binary-indexed demultiplexer.
//   The `NUM_SINKS, `LOG2_NUM_SINKS and `SINK_DATA_WIDTH macros can be
//   overridden on the tool command line. Their defaults live here, together
//   with the buffer-occupancy encodings.
//   Contents:
//     NUM_SINKS / LOG2_NUM_SINKS / SINK_DATA_WIDTH : default geometry
//     occ_e     : buffer occupancy state (EMPTY / HALF / FULL)
//     sat_inc8  : saturating 8-bit increment used by the drop counter
// -----------------------------------------------------------------------------
`ifndef NUM_SINKS
`define NUM_SINKS 64
`endif
`ifndef LOG2_NUM_SINKS
`define LOG2_NUM_SINKS 6
`endif
`ifndef SINK_DATA_WIDTH
`define SINK_DATA_WIDTH 32
`endif
`ifndef OCC_EMPTY_ENC
`define OCC_EMPTY_ENC 2'd0
`endif
`ifndef OCC_HALF_ENC
`define OCC_HALF_ENC 2'd1
`endif
`ifndef OCC_FULL_ENC
`define OCC_FULL_ENC 2'd2
`endif

package bin_demux_dec_pkg;

  localparam int NUM_SINKS       = `NUM_SINKS;
  localparam int LOG2_NUM_SINKS  = `LOG2_NUM_SINKS;
  localparam int SINK_DATA_WIDTH = `SINK_DATA_WIDTH;

  typedef enum logic [1:0] {
    OCC_EMPTY = `OCC_EMPTY_ENC,
    OCC_HALF  = `OCC_HALF_ENC,
    OCC_FULL  = `OCC_FULL_ENC
  } occ_e;

  // Counter sticks at 255 instead of wrapping to 0.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/bin_demux_dec_onehot.sv
// -----------------------------------------------------------------------------
// bin_dec_onehot
//   Purely combinational index decoder.
//   Ports:
//     idx      : binary sink index
//     onehot   : one bit set at position idx, all-zero when idx is out of range
//     in_range : 1 when idx < N_SINKS
// -----------------------------------------------------------------------------
module bin_dec_onehot
  import bin_demux_dec_pkg::*;
#(
  parameter int N_SINKS = NUM_SINKS,
  parameter int IDX_W   = LOG2_NUM_SINKS
) (
  input  logic [IDX_W-1:0]   idx,
  output logic [N_SINKS-1:0] onehot,
  output logic               in_range
);

  always_comb begin
    onehot   = '0;
    // The index field can encode more values than there are sinks when
    // N_SINKS is not a power of two, so range-check before decoding.
    in_range = ({{(32-IDX_W){1'b0}}, idx} < 32'(N_SINKS));
    if (in_range) begin
      onehot[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/bin_demux_dec.sv
// -----------------------------------------------------------------------------
// bin_demux_dec
//   Routes items from one source to one of N_SINKS sinks, selected by a
//   binary index. A 2-entry in-order buffer decouples the source from the
//   sinks. Out-of-range indices are swallowed, flagged on err_pulse and
//   counted in drop_cnt.
//
//   Handshake semantics: on both sides a transfer happens on a rising clk
//   edge where valid and ready are both 1. A producer holds valid and its
//   payload stable until that edge, and ready never depends combinationally
//   on valid. On the sink side, valid is the one-hot out_valids and
//   sink_readys[i] is the ready of sink i; only the selected bit matters.
//
//   Ports:
//     clk, rst     : clock, asynchronous active-high reset
//     in_valid     : source offers an item
//     in_ready     : buffer can accept (registered, low when FULL)
//     in_idx       : destination sink index
//     in_data      : payload
//     out_valids   : one-hot valid at the head item's sink
//     out_data     : head payload, shared by all sinks
//     sink_readys  : per-sink ready
//     err_pulse    : one-cycle pulse after an out-of-range item is accepted
//     drop_cnt     : saturating count of out-of-range items
// -----------------------------------------------------------------------------
module bin_demux_dec
  import bin_demux_dec_pkg::*;
#(
  parameter int N_SINKS = NUM_SINKS,
  parameter int IDX_W   = LOG2_NUM_SINKS,
  parameter int DATA_W  = SINK_DATA_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IDX_W-1:0]   in_idx,
  input  logic [DATA_W-1:0]  in_data,
  output logic [N_SINKS-1:0] out_valids,
  output logic [DATA_W-1:0]  out_data,
  input  logic [N_SINKS-1:0] sink_readys,
  output logic               err_pulse,
  output logic [7:0]         drop_cnt
);

  // Occupancy state; kept as a named enum register so checkers can bind to it.
  occ_e occ_q;
  occ_e occ_d;

  // Entries store the decoded sink select rather than the binary index, so
  // the head select can be loaded straight into out_valids.
  logic [N_SINKS-1:0] head_sel_q, head_sel_d;
  logic [N_SINKS-1:0] tail_sel_q, tail_sel_d;
  logic [DATA_W-1:0]  head_data_q, head_data_d;
  logic [DATA_W-1:0]  tail_data_q, tail_data_d;

  logic [N_SINKS-1:0] in_sel;
  logic               in_range;
  logic               accept;
  logic               store;
  logic               retire;

  bin_dec_onehot #(
    .N_SINKS (N_SINKS),
    .IDX_W   (IDX_W)
  ) u_in_dec (
    .idx      (in_idx),
    .onehot   (in_sel),
    .in_range (in_range)
  );

  assign accept = in_valid & in_ready;
  // Out-of-range items complete the handshake but never enter the buffer.
  assign store  = accept & in_range;
  // out_valids is zero when EMPTY and carries only the head bit otherwise,
  // so masking with it both detects the retire and ignores unselected sinks.
  assign retire = |(out_valids & sink_readys);

  always_comb begin
    occ_d       = occ_q;
    head_sel_d  = head_sel_q;
    head_data_d = head_data_q;
    tail_sel_d  = tail_sel_q;
    tail_data_d = tail_data_q;
    unique case (occ_q)
      OCC_EMPTY: begin
        if (store) begin
          occ_d       = OCC_HALF;
          head_sel_d  = in_sel;
          head_data_d = in_data;
        end
      end
      OCC_HALF: begin
        if (store && retire) begin
          // Head leaves as the new item arrives: new item becomes head.
          head_sel_d  = in_sel;
          head_data_d = in_data;
        end else if (store) begin
          occ_d       = OCC_FULL;
          tail_sel_d  = in_sel;
          tail_data_d = in_data;
        end else if (retire) begin
          occ_d = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        // in_ready is low here, so only a retire can happen.
        if (retire) begin
          occ_d       = OCC_HALF;
          head_sel_d  = tail_sel_q;
          head_data_d = tail_data_q;
        end
      end
      default: begin
        occ_d = OCC_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q       <= OCC_EMPTY;
      head_sel_q  <= '0;
      head_data_q <= '0;
      tail_sel_q  <= '0;
      tail_data_q <= '0;
      in_ready    <= 1'b0;
      out_valids  <= '0;
      out_data    <= '0;
      err_pulse   <= 1'b0;
      drop_cnt    <= 8'd0;
    end else begin
      occ_q       <= occ_d;
      head_sel_q  <= head_sel_d;
      head_data_q <= head_data_d;
      tail_sel_q  <= tail_sel_d;
      tail_data_q <= tail_data_d;
      // Outputs are registered copies of the next state, which gives the
      // one-cycle latency and lets in_ready come purely from flops.
      in_ready    <= (occ_d != OCC_FULL);
      out_valids  <= (occ_d != OCC_EMPTY) ? head_sel_d : '0;
      out_data    <= head_data_d;
      err_pulse   <= accept & ~in_range;
      if (accept && !in_range) begin
        drop_cnt <= sat_inc8(drop_cnt);
      end
    end
  end

endmodule

// File: tb/tb_bin_demux_dec.sv
// -----------------------------------------------------------------------------
// tb_bin_demux_dec
//   Bench for bin_demux_dec. "dut" uses the default 64-sink geometry; "dut48"
//   uses 48 sinks with a 6-bit index so out-of-range items can be offered.
//   A queue-based reference model predicts every output after every edge.
// -----------------------------------------------------------------------------
module tb_bin_demux_dec;

  localparam int NS  = 64;
  localparam int NSB = 48;
  localparam int IW  = 6;
  localparam int DW  = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- dut (64 sinks) ----------------
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_idx;
  logic [DW-1:0] in_data;
  logic [NS-1:0] out_valids;
  logic [DW-1:0] out_data;
  logic [NS-1:0] sink_readys;
  logic          err_pulse;
  logic [7:0]    drop_cnt;

  bin_demux_dec #(.N_SINKS(NS), .IDX_W(IW), .DATA_W(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_idx      (in_idx),
    .in_data     (in_data),
    .out_valids  (out_valids),
    .out_data    (out_data),
    .sink_readys (sink_readys),
    .err_pulse   (err_pulse),
    .drop_cnt    (drop_cnt)
  );

  // ---------------- dut48 (48 sinks) ----------------
  logic           b_valid;
  logic           b_ready;
  logic [IW-1:0]  b_idx;
  logic [DW-1:0]  b_data;
  logic [NSB-1:0] b_out_valids;
  logic [DW-1:0]  b_out_data;
  logic [NSB-1:0] b_sinks;
  logic           b_err;
  logic [7:0]     b_drop;

  bin_demux_dec #(.N_SINKS(NSB), .IDX_W(IW), .DATA_W(DW)) dut48 (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (b_valid),
    .in_ready    (b_ready),
    .in_idx      (b_idx),
    .in_data     (b_data),
    .out_valids  (b_out_valids),
    .out_data    (b_out_data),
    .sink_readys (b_sinks),
    .err_pulse   (b_err),
    .drop_cnt    (b_drop)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [IW+DW-1:0] exp_q[$];   // buffered items {idx, data}, head at [0]
  bit m_ready, m_err;
  int m_drop;
  bit mb_ready, mb_err;         // dut48 only ever sees out-of-range items
  int mb_drop;
  bit last_acc;
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ready  = 1'b0;
    m_err    = 1'b0;
    m_drop   = 0;
    mb_ready = 1'b0;
    mb_err   = 1'b0;
    mb_drop  = 0;
    last_acc = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valids"}, out_valids, 64'd0);
    check({tag, "_out_data"},   out_data,   64'd0);
    check({tag, "_in_ready"},   in_ready,   64'd0);
    check({tag, "_err_pulse"},  err_pulse,  64'd0);
    check({tag, "_drop_cnt"},   drop_cnt,   64'd0);
    check({tag, "_b_out_valids"}, b_out_valids, 64'd0);
    check({tag, "_b_in_ready"}, b_ready,    64'd0);
    check({tag, "_b_drop_cnt"}, b_drop,     64'd0);
  endtask

  // One clock: predict the edge from the current inputs, step to edge+1,
  // update the model and compare every output of both instances.
  task automatic cycle();
    bit acc, ret, b_acc;
    logic [IW+DW-1:0] h;
    logic [IW-1:0] hidx;
    acc   = in_valid && m_ready;
    b_acc = b_valid && mb_ready;
    ret   = 1'b0;
    if (exp_q.size() > 0) begin
      h    = exp_q[0];
      hidx = h[IW+DW-1:DW];
      ret  = sink_readys[hidx];
    end
    @(posedge clk);
    #1;
    if (ret) void'(exp_q.pop_front());
    m_err = acc && (int'(in_idx) >= NS);
    if (acc && !m_err) exp_q.push_back({in_idx, in_data});
    if (m_err && m_drop < 255) m_drop++;
    m_ready  = (exp_q.size() < 2);
    mb_err   = b_acc && (int'(b_idx) >= NSB);
    if (mb_err && mb_drop < 255) mb_drop++;
    mb_ready = 1'b1;
    last_acc = acc;

    if (exp_q.size() > 0) begin
      h    = exp_q[0];
      hidx = h[IW+DW-1:DW];
      check("out_valids", out_valids, 64'd1 << hidx);
      check("out_data", out_data, 64'(h[DW-1:0]));
    end else begin
      check("out_valids_idle", out_valids, 64'd0);
    end
    check("onehot", 64'($countones(out_valids) <= 1), 64'd1);
    check("in_ready", in_ready, 64'(m_ready));
    check("err_pulse", err_pulse, 64'(m_err));
    check("drop_cnt", drop_cnt, 64'(m_drop));
    check("b_out_valids", b_out_valids, 64'd0);
    check("b_in_ready", b_ready, 64'(mb_ready));
    check("b_err_pulse", b_err, 64'(mb_err));
    check("b_drop_cnt", b_drop, 64'(mb_drop));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int nz_cnt;
    int err_cnt;
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_idx      = '0;
    in_data     = '0;
    sink_readys = '1;
    b_valid     = 1'b0;
    b_idx       = '0;
    b_data      = '0;
    b_sinks     = '1;
    model_reset();

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    cycle();
    check("ready_after_release", in_ready, 64'd1);

    // Single item to sink 5.
    in_valid = 1'b1; in_idx = 6'd5; in_data = 32'hA5A5A5A5;
    cycle();
    check("single_valids", out_valids, 64'd1 << 5);
    check("single_data", out_data, 64'hA5A5A5A5);
    in_valid = 1'b0;
    cycle();
    check("single_gone", out_valids, 64'd0);

    // Back-pressure: 63 and 0 fill the buffer, 17 waits at the source.
    sink_readys = '0;
    in_valid = 1'b1; in_idx = 6'd63; in_data = $urandom;
    cycle();
    in_idx = 6'd0; in_data = $urandom;
    cycle();
    check("bp_full_ready", in_ready, 64'd0);
    in_idx = 6'd17; in_data = $urandom;
    for (int i = 0; i < 8; i++) cycle();
    check("bp_head_held", out_valids, 64'd1 << 63);
    sink_readys = '1;
    cycle();
    check("bp_second", out_valids, 64'd1);
    cycle();
    check("bp_third", out_valids, 64'd1 << 17);
    in_valid = 1'b0;
    cycle();
    check("bp_drained", out_valids, 64'd0);

    // Ready on an unselected sink must not retire the head.
    in_valid = 1'b1; in_idx = 6'd3; in_data = $urandom;
    sink_readys = 64'd1 << 4;
    cycle();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("unsel_hold", out_valids, 64'd1 << 3);
    end
    sink_readys = '1;
    cycle();
    check("unsel_retired", out_valids, 64'd0);

    // Streaming: 100 back-to-back items, every sink ready.
    nz_cnt = 0;
    for (int i = 0; i < 101; i++) begin
      in_valid = (i < 100);
      in_idx   = 6'($urandom_range(0, 63));
      in_data  = $urandom;
      cycle();
      if (i < 100) check("stream_accept", 64'(last_acc), 64'd1);
      if (out_valids != '0) nz_cnt++;
    end
    in_valid = 1'b0;
    check("stream_deliveries", 64'(nz_cnt), 64'd100);
    cycle();
    check("stream_drained", out_valids, 64'd0);

    // Random traffic with random per-sink readiness.
    last_acc = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!in_valid || last_acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_idx   = 6'($urandom_range(0, 63));
        in_data  = $urandom;
      end
      sink_readys = {$urandom, $urandom};
      cycle();
    end
    in_valid = 1'b0;
    sink_readys = '1;
    repeat (3) cycle();

    // Reset pulse between edges with the buffer FULL.
    sink_readys = '0;
    in_valid = 1'b1; in_idx = 6'd9; in_data = $urandom;
    cycle();
    in_idx = 6'd40; in_data = $urandom;
    cycle();
    in_valid = 1'b0;
    check("mid_full_ready", in_ready, 64'd0);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    #2 rst = 1'b0;
    model_reset();
    sink_readys = '1;
    cycle();
    check("mid_ready_after", in_ready, 64'd1);
    check("mid_no_stale", out_valids, 64'd0);
    repeat (3) cycle();

    // Out-of-range on the 48-sink instance: 300 drops, counter saturates.
    err_cnt = 0;
    b_idx = 6'd50;
    for (int i = 0; i < 301; i++) begin
      b_valid = (i < 300);
      b_data  = $urandom;
      cycle();
      if (b_err) err_cnt++;
    end
    b_valid = 1'b0;
    check("oor_err_cycles", 64'(err_cnt), 64'd300);
    check("oor_drop_sat", b_drop, 64'd255);
    cycle();
    check("oor_err_quiet", b_err, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
